// File: rtl/credit_stats_regs.sv
// CSR responder for per-port buffer-to-buffer credit statistics.
// Single-cycle register reads/writes plus link-event driven credit counters.
module credit_stats_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] iADDR,
  input  logic [63:0] iWR_DATA,
  input  logic        iWR_EN,
  input  logic        iRD_EN,
  output logic [63:0] oRD_DATA,
  output logic        oRD_DATA_V,
  input  logic        iTX_FRAME,
  input  logic        iRX_RRDY
);

  localparam logic [9:0] A_CTRL    = 10'h000;
  localparam logic [9:0] A_SCRATCH = 10'h001;
  localparam logic [9:0] A_TX_CNT  = 10'h002;
  localparam logic [9:0] A_RX_CNT  = 10'h003;
  localparam logic [9:0] A_CREDIT  = 10'h004;
  localparam logic [9:0] A_ZERO    = 10'h005;
  localparam logic [9:0] A_MIN     = 10'h006;
  localparam logic [9:0] A_CMD     = 10'h007;
  localparam logic [9:0] A_STATUS  = 10'h008;

  localparam int NCNT = 3;

  logic        ctrl_en_q,  ctrl_en_d;
  logic        ctrl_cor_q, ctrl_cor_d;
  logic [15:0] credit_init_q, credit_init_d;
  logic [63:0] scratch_q, scratch_d;
  logic [15:0] credit_q, credit_d;
  logic [15:0] min_credit_q, min_credit_d;
  logic [1:0]  status_q, status_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        rd_v_q;

  logic [47:0] cnt_q [NCNT];
  logic [47:0] cnt_d [NCNT];

  logic [8:0]  addr_hit;
  logic        cmd_clear, cmd_reload, cmd_any;
  logic        ev_live, tx_ev, rx_ev, zero_ev;
  logic        dec, inc, underflow, overflow;
  logic [1:0]  w1c_mask;
  logic [NCNT-1:0] cnt_ev, cnt_cor;
  logic        unused_addr;

  assign unused_addr = ^iADDR[13:10];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_decode
      assign addr_hit[gi] = (iADDR[9:0] == 10'(gi));
    end
  endgenerate

  assign cmd_clear  = iWR_EN & addr_hit[A_CMD] & iWR_DATA[0];
  assign cmd_reload = iWR_EN & addr_hit[A_CMD] & iWR_DATA[1];
  assign cmd_any    = cmd_clear | cmd_reload;

  // Link events in a CMD cycle are dropped entirely: the command owns every stat that cycle.
  assign ev_live  = ctrl_en_q & ~cmd_any;
  assign tx_ev    = ev_live & iTX_FRAME;
  assign rx_ev    = ev_live & iRX_RRDY;
  assign zero_ev  = ev_live & (credit_q == 16'h0000);

  assign dec       = tx_ev & ~rx_ev;
  assign inc       = rx_ev & ~tx_ev;
  assign underflow = dec & (credit_q == 16'h0000);
  assign overflow  = inc & (credit_q == 16'hFFFF);

  assign w1c_mask = (iWR_EN & addr_hit[A_STATUS]) ? iWR_DATA[1:0] : 2'b00;

  assign cnt_ev  = {zero_ev, rx_ev, tx_ev};
  assign cnt_cor = {3{ctrl_cor_q & iRD_EN}} &
                   {addr_hit[A_ZERO], addr_hit[A_RX_CNT], addr_hit[A_TX_CNT]};

  generate
    for (gi = 0; gi < NCNT; gi++) begin : g_cnt
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (cmd_clear) begin
          cnt_d[gi] = '0;
        end else if (cnt_cor[gi]) begin
          cnt_d[gi] = {47'b0, cnt_ev[gi]};
        end else if (cnt_ev[gi] && (cnt_q[gi] != {48{1'b1}})) begin
          cnt_d[gi] = cnt_q[gi] + 48'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    credit_d = credit_q;
    if (cmd_reload) begin
      credit_d = credit_init_q;
    end else if (dec && !underflow) begin
      credit_d = credit_q - 16'd1;
    end else if (inc && !overflow) begin
      credit_d = credit_q + 16'd1;
    end
  end

  // Reload wins over clear for the credit watermark when both CMD bits are set.
  always_comb begin
    min_credit_d = min_credit_q;
    if (cmd_reload) begin
      min_credit_d = credit_init_q;
    end else if (cmd_clear) begin
      min_credit_d = credit_q;
    end else if (ctrl_en_q && (credit_d < min_credit_q)) begin
      min_credit_d = credit_d;
    end
  end

  always_comb begin
    if (cmd_clear) begin
      status_d = 2'b00;
    end else begin
      status_d = (status_q & ~w1c_mask) | {overflow, underflow};
    end
  end

  always_comb begin
    ctrl_en_d     = ctrl_en_q;
    ctrl_cor_d    = ctrl_cor_q;
    credit_init_d = credit_init_q;
    scratch_d     = scratch_q;
    if (iWR_EN && addr_hit[A_CTRL]) begin
      ctrl_en_d     = iWR_DATA[0];
      ctrl_cor_d    = iWR_DATA[1];
      credit_init_d = iWR_DATA[31:16];
    end
    if (iWR_EN && addr_hit[A_SCRATCH]) begin
      scratch_d = iWR_DATA;
    end
  end

  // Read mux sees pre-edge state, so a same-cycle write or clear returns the old value.
  always_comb begin
    rd_data_d = rd_data_q;
    if (iRD_EN) begin
      case (iADDR[9:0])
        A_CTRL:    rd_data_d = {32'h0, credit_init_q, 14'h0, ctrl_cor_q, ctrl_en_q};
        A_SCRATCH: rd_data_d = scratch_q;
        A_TX_CNT:  rd_data_d = {16'h0, cnt_q[0]};
        A_RX_CNT:  rd_data_d = {16'h0, cnt_q[1]};
        A_CREDIT:  rd_data_d = {48'h0, credit_q};
        A_ZERO:    rd_data_d = {16'h0, cnt_q[2]};
        A_MIN:     rd_data_d = {48'h0, min_credit_q};
        A_CMD:     rd_data_d = 64'h0;
        A_STATUS:  rd_data_d = {62'h0, status_q};
        default:   rd_data_d = {32'h0BAD_ADD0, 22'h0, iADDR[9:0]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en_q     <= 1'b0;
      ctrl_cor_q    <= 1'b0;
      credit_init_q <= 16'h0;
      scratch_q     <= 64'h0;
      credit_q      <= 16'h0;
      min_credit_q  <= 16'hFFFF;
      status_q      <= 2'b00;
      rd_data_q     <= 64'h0;
      rd_v_q        <= 1'b0;
    end else begin
      ctrl_en_q     <= ctrl_en_d;
      ctrl_cor_q    <= ctrl_cor_d;
      credit_init_q <= credit_init_d;
      scratch_q     <= scratch_d;
      credit_q      <= credit_d;
      min_credit_q  <= min_credit_d;
      status_q      <= status_d;
      rd_data_q     <= rd_data_d;
      rd_v_q        <= iRD_EN;
    end
  end

  assign oRD_DATA   = rd_data_q;
  assign oRD_DATA_V = rd_v_q;

endmodule

// File: tb/tb_credit_stats_regs.sv
// Randomised bench for credit_stats_regs against a cycle-level behavioural model,
// with directed scenarios pinned to hand-computed read values.
module tb_credit_stats_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] iADDR = '0;
  logic [63:0] iWR_DATA = '0;
  logic        iWR_EN = 1'b0;
  logic        iRD_EN = 1'b0;
  logic [63:0] oRD_DATA;
  logic        oRD_DATA_V;
  logic        iTX_FRAME = 1'b0;
  logic        iRX_RRDY = 1'b0;

  int checks = 0;
  int failures = 0;

  credit_stats_regs dut (
    .clk(clk), .rst_n(rst_n), .iADDR(iADDR), .iWR_DATA(iWR_DATA),
    .iWR_EN(iWR_EN), .iRD_EN(iRD_EN), .oRD_DATA(oRD_DATA), .oRD_DATA_V(oRD_DATA_V),
    .iTX_FRAME(iTX_FRAME), .iRX_RRDY(iRX_RRDY)
  );

  always #5 clk = ~clk;

  localparam longint unsigned MAX48 = 64'h0000_FFFF_FFFF_FFFF;

  // Behavioural model state
  bit              m_en, m_cor;
  int              m_init;
  logic [63:0]     m_scr;
  longint unsigned m_tx, m_rx, m_zc;
  int              m_cr, m_min;
  bit [1:0]        m_st;
  logic [63:0]     m_rd;
  bit              m_rv;

  task automatic model_reset();
    m_en = 0; m_cor = 0; m_init = 0; m_scr = '0;
    m_tx = 0; m_rx = 0; m_zc = 0; m_cr = 0; m_min = 65535; m_st = 0;
    m_rd = '0; m_rv = 0;
  endtask

  function automatic logic [63:0] model_read(input logic [13:0] a);
    logic [63:0] v;
    case (int'(a[9:0]))
      0: v = 64'(m_init) * 65536 + 64'(m_cor) * 2 + 64'(m_en);
      1: v = m_scr;
      2: v = m_tx;
      3: v = m_rx;
      4: v = 64'(m_cr);
      5: v = m_zc;
      6: v = 64'(m_min);
      7: v = 64'h0;
      8: v = 64'(m_st);
      default: v = {32'h0BAD_ADD0, 22'h0, a[9:0]};
    endcase
    return v;
  endfunction

  function automatic longint unsigned bump(input longint unsigned c, input bit ev,
                                           input bit cor_clr, input bit clr);
    longint unsigned n;
    n = (ev && c < MAX48) ? c + 1 : c;
    if (cor_clr) n = ev ? 1 : 0;
    if (clr) n = 0;
    return n;
  endfunction

  task automatic model_cycle(input logic [13:0] a, input logic [63:0] wd, input bit we,
                             input bit re, input bit tx, input bit rx);
    int  a10, nc, nmin;
    bit  clr, rld, live, t, r, z, uf, of;
    bit [1:0] st;
    a10 = int'(a[9:0]);
    m_rv = re;
    if (re) m_rd = model_read(a);
    clr  = we && a10 == 7 && wd[0];
    rld  = we && a10 == 7 && wd[1];
    live = m_en && !clr && !rld;
    t = live && tx;
    r = live && rx;
    z = live && m_cr == 0;
    m_tx = bump(m_tx, t, m_cor && re && a10 == 2, clr);
    m_rx = bump(m_rx, r, m_cor && re && a10 == 3, clr);
    m_zc = bump(m_zc, z, m_cor && re && a10 == 5, clr);
    uf = 0; of = 0;
    nc = m_cr + ((t && !r) ? -1 : 0) + ((r && !t) ? 1 : 0);
    if (nc < 0) begin nc = 0; uf = 1; end
    if (nc > 65535) begin nc = 65535; of = 1; end
    if (rld) nc = m_init;
    if (rld) nmin = m_init;
    else if (clr) nmin = m_cr;
    else if (m_en) nmin = (nc < m_min) ? nc : m_min;
    else nmin = m_min;
    st = m_st;
    if (we && a10 == 8) st = st & ~wd[1:0];
    st = st | {of, uf};
    if (clr) st = 0;
    m_cr = nc; m_min = nmin; m_st = st;
    if (we && a10 == 0) begin
      m_en = wd[0]; m_cor = wd[1]; m_init = int'(wd[31:16]);
    end
    if (we && a10 == 1) m_scr = wd;
  endtask

  // One bus cycle: drive, clock, advance model, compare outputs just after the edge.
  task automatic step(input logic [13:0] a, input logic [63:0] wd, input bit we, input bit re,
                      input bit tx, input bit rx, input bit lc, input logic [63:0] lit);
    iADDR = a; iWR_DATA = wd; iWR_EN = we; iRD_EN = re; iTX_FRAME = tx; iRX_RRDY = rx;
    @(posedge clk);
    model_cycle(a, wd, we, re, tx, rx);
    #1;
    checks++;
    if (oRD_DATA_V !== m_rv) begin
      failures++;
      $display("FAIL rd_valid addr=%h: got %b expected %b", a, oRD_DATA_V, m_rv);
    end
    checks++;
    if (oRD_DATA !== m_rd) begin
      failures++;
      $display("FAIL rd_data addr=%h: got %h expected %h", a, oRD_DATA, m_rd);
    end
    if (lc) begin
      checks++;
      if (oRD_DATA_V !== 1'b1 || oRD_DATA !== lit) begin
        failures++;
        $display("FAIL literal addr=%h: got %h (v=%b) expected %h", a, oRD_DATA, oRD_DATA_V, lit);
      end
    end
    iWR_EN = 0; iRD_EN = 0; iTX_FRAME = 0; iRX_RRDY = 0;
  endtask

  task automatic rd(input logic [13:0] a, input bit lc, input logic [63:0] lit);
    step(a, 64'h0, 0, 1, 0, 0, lc, lit);
  endtask

  task automatic wr(input logic [13:0] a, input logic [63:0] d);
    step(a, d, 1, 0, 0, 0, 0, 64'h0);
  endtask

  task automatic ev(input bit tx, input bit rx);
    step(14'h0, 64'h0, 0, 0, tx, rx, 0, 64'h0);
  endtask

  logic [63:0] reset_exp [9];

  initial begin
    reset_exp = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'hFFFF, 64'h0, 64'h0};
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (oRD_DATA_V !== 1'b0 || oRD_DATA !== 64'h0) begin
      failures++;
      $display("FAIL reset_out: got %h v=%b expected 0 v=0", oRD_DATA, oRD_DATA_V);
    end

    for (int i = 0; i < 9; i++) rd(14'(i), 1, reset_exp[i]);
    rd({4'hA, 10'h3FF}, 1, 64'h0BAD_ADD0_0000_03FF);

    // Enable with credit_init=8, reload, 3 frames then one R_RDY
    wr(14'h0, 64'h0008_0001);
    wr(14'h7, 64'h2);
    ev(1, 0); ev(1, 0); ev(1, 0); ev(0, 1);
    rd(14'h4, 1, 64'd6);
    rd(14'h6, 1, 64'd5);
    rd(14'h2, 1, 64'd3);
    rd(14'h3, 1, 64'd1);

    // Reload to 1, drain past zero, count zero-credit cycles
    wr(14'h0, 64'h0001_0001);
    wr(14'h7, 64'h2);
    ev(1, 0); ev(1, 0);
    repeat (4) ev(0, 0);
    rd(14'h5, 1, 64'd5);
    rd(14'h4, 1, 64'd0);
    rd(14'h8, 1, 64'h1);
    wr(14'h8, 64'h1);
    rd(14'h8, 1, 64'h0);

    // Clear-on-read with a coincident frame
    wr(14'h0, 64'h0001_0003);
    rd(14'h2, 1, 64'd5);
    repeat (10) ev(1, 0);
    step(14'h2, 64'h0, 0, 1, 1, 0, 1, 64'd10);
    rd(14'h2, 1, 64'd1);

    // Simultaneous events at zero credit, then scratch write/read collision
    wr(14'h8, 64'h3);
    step(14'h0, 64'h0, 0, 0, 1, 1, 0, 64'h0);
    rd(14'h4, 1, 64'd0);
    rd(14'h8, 1, 64'h0);
    step(14'h1, 64'hDEAD_BEEF_CAFE_F00D, 1, 1, 0, 0, 1, 64'h0);
    rd(14'h1, 1, 64'hDEAD_BEEF_CAFE_F00D);

    // Randomised traffic, with phases biased towards draining or filling credits
    for (int i = 0; i < 4000; i++) begin
      logic [13:0] a;
      logic [63:0] d;
      bit we, re, tx, rx;
      int phase;
      phase = (i / 250) % 3;
      if ($urandom_range(15) == 0) a = 14'($urandom);
      else a = {4'($urandom), 10'($urandom_range(8))};
      d = {$urandom, $urandom};
      we = ($urandom_range(4) == 0);
      re = ($urandom_range(2) == 0);
      if (we && a[9:0] == 10'h7 && $urandom_range(3) != 0) we = 0;
      if (we && a[9:0] == 10'h0) begin
        d[0] = ($urandom_range(7) != 0);
        case ($urandom_range(4))
          0: d[31:16] = 16'h0000;
          1: d[31:16] = 16'h0002;
          2: d[31:16] = 16'hFFFE;
          3: d[31:16] = 16'hFFFF;
          default: d[31:16] = 16'($urandom);
        endcase
      end
      tx = (phase == 2) ? ($urandom_range(4) == 0) : ($urandom_range(1) == 0);
      rx = (phase == 1) ? ($urandom_range(4) == 0) : ($urandom_range(1) == 0);
      step(a, d, we, re, tx, rx, 0, 64'h0);
    end

    // Reset asserted mid-read: no response pulse afterwards
    iADDR = 14'h1; iRD_EN = 1'b1;
    #3 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    iRD_EN = 1'b0;
    model_reset();
    ev(0, 0);
    checks++;
    if (oRD_DATA_V !== 1'b0 || oRD_DATA !== 64'h0) begin
      failures++;
      $display("FAIL reset_abort: got %h v=%b expected 0 v=0", oRD_DATA, oRD_DATA_V);
    end
    rd(14'h6, 1, 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/credit_stats_regs.md
# credit_stats_regs

CSR responder for per-port buffer-to-buffer credit statistics. It terminates the CREDIT_STATS0/CREDIT_STATS1 register interface driven by the address decoder's clock-domain-crossing path, on the port clock side. It decodes the word address, services single-cycle reads and writes, and maintains credit-tracking counters fed by link events.

## Interface
- No parameters.
- clk  in  1  port clock
- rst_n  in  1  reset, asynchronous, active-low
- iADDR  in  14  word address; only [9:0] decoded
- iWR_DATA  in  64  write data
- iWR_EN  in  1  write strobe, one cycle per access
- iRD_EN  in  1  read strobe, one cycle per access
- oRD_DATA  out  64  read data
- oRD_DATA_V  out  1  read data valid, one-cycle pulse
- iTX_FRAME  in  1  frame transmitted; consumes one credit
- iRX_RRDY  in  1  R_RDY received; returns one credit

## Operation
- Register map (iADDR[9:0]):
  - 0x000 CTRL, RW, reset 0: [0] enable, [1] clear_on_read, [31:16] credit_init.
  - 0x001 SCRATCH, RW 64, reset 0.
  - 0x002 TX_FRAME_CNT, RO, 48-bit.
  - 0x003 RX_RRDY_CNT, RO, 48-bit.
  - 0x004 CREDIT_AVAIL, RO, 16-bit, reset 0.
  - 0x005 ZERO_CREDIT_CYC, RO, 48-bit.
  - 0x006 MIN_CREDIT, RO, 16-bit, reset 0xFFFF.
  - 0x007 CMD, WO, reads 0: [0] clear stats (0x002, 0x003, 0x005, STATUS; MIN_CREDIT is set to CREDIT_AVAIL); [1] reload (CREDIT_AVAIL and MIN_CREDIT are set to credit_init).
  - 0x008 STATUS, RW1C: [0] underflow sticky, [1] overflow sticky.
- Unused upper bits of narrow registers read 0.
- Unmapped read returns {32'h0BAD_ADD0, 22'b0, iADDR[9:0]}. Unmapped write is ignored.
- Counters run only while enable=1. The 48-bit counters saturate at all-ones and do not wrap.
- CREDIT_AVAIL update:
  - iTX_FRAME alone: minus 1.
  - iRX_RRDY alone: plus 1.
  - Both asserted: unchanged, and no flags set.
  - Decrement at 0: value stays 0 and STATUS[0] is set.
  - Increment at 0xFFFF: value stays 0xFFFF and STATUS[1] is set.
- ZERO_CREDIT_CYC increments every cycle with enable=1 and CREDIT_AVAIL==0, evaluated on the current value.
- MIN_CREDIT is set to min(MIN_CREDIT, next CREDIT_AVAIL) every enabled cycle.
- clear_on_read: a read of 0x002, 0x003 or 0x005 returns the pre-clear value and zeroes that counter at the same edge.
  - An event in the clearing cycle is kept: the counter becomes 1.
- Priority per counter, highest first: CMD clear/reload, then clear_on_read, then event update.
  - An event in the same cycle as CMD clear is dropped.
- Simultaneous iWR_EN and iRD_EN: both are performed. If the address is the same, the read returns the old value.
- STATUS W1C coincident with a new flag set: the flag stays set.

## Timing
- Read: iRD_EN sampled at edge N. oRD_DATA and oRD_DATA_V are registered at edge N and visible for cycle N+1. oRD_DATA_V is high for exactly one cycle per iRD_EN.
- oRD_DATA holds its last value between reads.
- Back-to-back reads on consecutive cycles are supported, one response per cycle.
- Write: takes effect at the sampling edge. A read issued in the next cycle sees the new value.
- CMD bits self-clear and act only in the write cycle.
- Event inputs are sampled every edge, with no pipelining. CREDIT_AVAIL reflects an event one cycle later.
- Reset:
  - oRD_DATA=0, oRD_DATA_V=0.
  - All registers take the reset values listed above.
  - Reset asserted mid-access aborts it: no oRD_DATA_V pulse follows reset release.

## Test plan
- Reset, then read 0x000–0x008: responses 0,0,0,0,0,0,0xFFFF,0,0, each with oRD_DATA_V exactly one cycle after iRD_EN. Read 0x3FF: returns 0x0BAD_ADD0_0000_03FF.
- Write CTRL=0x0008_0001, CMD=0x2, then 3 iTX_FRAME and 1 iRX_RRDY: CREDIT_AVAIL=6, MIN_CREDIT=5, TX_FRAME_CNT=3, RX_RRDY_CNT=1.
- Reload with credit_init=1, then 2 iTX_FRAME and 4 idle cycles:
  - CREDIT_AVAIL=0, STATUS=0x1.
  - ZERO_CREDIT_CYC=5 (1 cycle after the second frame plus 4 idle).
  - Write STATUS=0x1, read STATUS: returns 0.
- Set clear_on_read, accumulate TX_FRAME_CNT=10, read 0x002 with iTX_FRAME asserted in the same cycle: read returns 10, the next read returns 1.
- iTX_FRAME and iRX_RRDY asserted together at CREDIT_AVAIL=0: value stays 0, STATUS stays 0. SCRATCH write 0xDEAD_BEEF_CAFE_F00D with a same-cycle read: the read returns the old value, the next read returns the new value.
